seg14_scan_ctl: RTL and testbench



---
 rtl/seg14_scan_pkg.sv | 14 +
 rtl/seg14_scan_ctl_if.sv | 12 +
 rtl/seg14_slot_timer.sv | 17 +
 rtl/seg14_scan_ctl.sv | 87 ++++++++
 tb/tb_seg14_scan_ctl.sv | 108 ++++++++++
 5 files changed

// File: rtl/seg14_scan_pkg.sv
// seg14_scan_pkg: shared state encoding, digit constants and leading-zero mask helper for the 14-segment scan controller
package seg14_scan_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;
  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] DIGITS_OFF = 4'b1111;
  function automatic logic [3:0] lz_mask(input logic [15:0] snap);
    logic [3:0] m;
    m[3] = snap[15:12] == 4'd0;
    m[2] = m[3] && snap[11:8] == 4'd0;
    m[1] = m[2] && snap[7:4] == 4'd0;
    m[0] = 1'b0;
    return m;
  endfunction
endpackage

// File: rtl/seg14_scan_ctl_if.sv
// seg14_scan_ctl_if: scan controller bus; master drives en/bcd_in/blank_lz, slave drives bcd_out/digit_sel/digit_idx/frame_tick
interface seg14_scan_ctl_if;
  logic en;
  logic [15:0] bcd_in;
  logic blank_lz;
  logic [3:0] bcd_out;
  logic [3:0] digit_sel;
  logic [1:0] digit_idx;
  logic frame_tick;
  modport master (output en, bcd_in, blank_lz, input bcd_out, digit_sel, digit_idx, frame_tick);
  modport slave (input en, bcd_in, blank_lz, output bcd_out, digit_sel, digit_idx, frame_tick);
endinterface

// File: rtl/seg14_slot_timer.sv
// seg14_slot_timer: loadable down-counter (clk, rst, load, load_val in; done out when count is zero)
module seg14_slot_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/seg14_scan_ctl.sv
// seg14_scan_ctl: 4-digit 14-segment scan controller (clk, rst, bus: en/bcd_in/blank_lz in, bcd_out/digit_sel/digit_idx/frame_tick out)
module seg14_scan_ctl
  import seg14_scan_pkg::*;
#(
  parameter int DWELL_CYC = 50000,
  parameter int DEAD_CYC  = 500,
  parameter int CNT_W     = 16
) (
  input logic             clk,
  input logic             rst,
  seg14_scan_ctl_if.slave bus
);
  state_t state, nstate;
  logic [1:0] idx, nidx;
  logic [15:0] snap, nsnap;
  logic lz, nlz, tick, load, done;
  logic [CNT_W-1:0] lval;
  logic [3:0] nmask;
  seg14_slot_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst(rst), .load(load), .load_val(lval), .done(done)
  );
  always_comb begin
    nstate = state;
    nidx = idx;
    nsnap = snap;
    nlz = lz;
    tick = 1'b0;
    load = 1'b0;
    lval = '0;
    if (!bus.en) begin
      nstate = ST_IDLE;
      nidx = 2'd0;
      load = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          nstate = ST_BLANK;
          nidx = 2'd0;
          nsnap = bus.bcd_in;
          nlz = bus.blank_lz;
          tick = 1'b1;
          load = 1'b1;
          lval = CNT_W'(DEAD_CYC - 1);
        end
        ST_BLANK: if (done) begin
          nstate = ST_SHOW;
          load = 1'b1;
          lval = CNT_W'(DWELL_CYC - 1);
        end
        ST_SHOW: if (done) begin
          nstate = ST_BLANK;
          nidx = idx + 2'd1;
          load = 1'b1;
          lval = CNT_W'(DEAD_CYC - 1);
          if (idx == 2'(NUM_DIGITS - 1)) begin
            nsnap = bus.bcd_in;
            nlz = bus.blank_lz;
            tick = 1'b1;
          end
        end
        default: nstate = ST_IDLE;
      endcase
    end
    nmask = lz_mask(nsnap) & {4{nlz}};
  end
  // outputs are registered from the next-state view so they change on the same edge as the state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      idx <= 2'd0;
      snap <= 16'h0000;
      lz <= 1'b0;
      bus.digit_sel <= DIGITS_OFF;
      bus.bcd_out <= 4'd0;
      bus.digit_idx <= 2'd0;
      bus.frame_tick <= 1'b0;
    end else begin
      state <= nstate;
      idx <= nidx;
      snap <= nsnap;
      lz <= nlz;
      bus.digit_sel <= (nstate == ST_SHOW && !nmask[nidx]) ? ~(4'b0001 << nidx) : DIGITS_OFF;
      bus.bcd_out <= nstate == ST_IDLE ? 4'd0 : nsnap[{nidx, 2'b00} +: 4];
      bus.digit_idx <= nidx;
      bus.frame_tick <= tick;
    end
endmodule

// File: tb/tb_seg14_scan_ctl.sv
// tb_seg14_scan_ctl: randomized scoreboard bench for seg14_scan_ctl against a frame-position reference model
module tb_seg14_scan_ctl;
  localparam int DWELL = 4;
  localparam int DEAD = 2;
  localparam int SLOT = DWELL + DEAD;
  localparam int FRAME = 4 * SLOT;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int p = -1;
  logic [15:0] msnap = 16'h0;
  logic mlz = 1'b0;
  logic [10:0] expq[$];
  logic [10:0] mon_exp, mon_act;
  seg14_scan_ctl_if bus();
  seg14_scan_ctl #(.DWELL_CYC(DWELL), .DEAD_CYC(DEAD), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [10:0] expect_out(input int pos, input logic [15:0] s, input logic l);
    int slot, ph;
    logic [3:0] sel, d;
    logic sup;
    if (pos < 0) return {4'hF, 4'h0, 2'd0, 1'b0};
    slot = pos / SLOT;
    ph = pos % SLOT;
    d = 4'((s >> (4 * slot)) & 16'hF);
    sup = l && slot > 0 && (s >> (4 * slot)) == 16'h0;
    sel = (ph >= DEAD && !sup) ? ~(4'b0001 << slot) : 4'hF;
    return {sel, d, 2'(slot), pos == 0};
  endfunction
  task automatic step(input logic e, input logic [15:0] b, input logic l);
    bus.en = e;
    bus.bcd_in = b;
    bus.blank_lz = l;
    if (!e) p = -1;
    else if (p < 0 || p == FRAME - 1) begin
      p = 0;
      msnap = b;
      mlz = l;
    end else p++;
    expq.push_back(expect_out(p, msnap, mlz));
    @(negedge clk);
  endtask
  task automatic run(input int n, input logic e, input logic [15:0] b, input logic l);
    for (int i = 0; i < n; i++) step(e, b, l);
  endtask
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      mon_exp = expq.pop_front();
      mon_act = {bus.digit_sel, bus.bcd_out, bus.digit_idx, bus.frame_tick};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL scan t=%0t sel/bcd/idx/tick got %b/%h/%0d/%b want %b/%h/%0d/%b", $time,
                 mon_act[10:7], mon_act[6:3], mon_act[2:1], mon_act[0],
                 mon_exp[10:7], mon_exp[6:3], mon_exp[2:1], mon_exp[0]);
      end
    end
  end
  initial begin
    logic [15:0] rb;
    bus.en = 1'b0;
    bus.bcd_in = 16'h0;
    bus.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.digit_sel, bus.bcd_out, bus.digit_idx, bus.frame_tick} !== {4'hF, 4'h0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got %b/%h/%0d/%b want 1111/0/0/0", bus.digit_sel, bus.bcd_out, bus.digit_idx, bus.frame_tick);
    end
    rst = 1'b0;
    run(48, 1'b1, 16'h1234, 1'b0);
    run(48, 1'b1, 16'h0050, 1'b1);
    run(48, 1'b1, 16'h0000, 1'b1);
    run(10, 1'b1, 16'h1234, 1'b0);
    run(38, 1'b1, 16'h9876, 1'b0);
    run(16, 1'b1, 16'h5555, 1'b0);
    run(5, 1'b0, 16'h5555, 1'b0);
    run(34, 1'b1, 16'h4321, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.digit_sel !== 4'hF || bus.bcd_out !== 4'h0) begin
      errors++;
      $display("FAIL async_reset got sel %b bcd %h want 1111 0", bus.digit_sel, bus.bcd_out);
    end
    @(negedge clk);
    rst = 1'b0;
    p = -1;
    run(30, 1'b1, 16'h7777, 1'b0);
    run(48, 1'b1, 16'hA00B, 1'b1);
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++)
        rb[4*k +: 4] = $urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom_range(0, 15));
      step($urandom_range(0, 29) != 0, rb, 1'($urandom_range(0, 1)));
    end
    repeat (2) @(negedge clk);
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
